// File: rtl/simplemem_ctrl.sv
// simplemem_ctrl: host-side sequencer for the asynchronous simplemem SRAM.
// Converts single-cycle host requests into timed csN/oeN/wrN sequences with
// programmable wait states and owns the direction of the shared data bus.
// Every memory-facing control is taken straight from a flop so the SRAM never
// sees decode glitches; the bus enable is a flop as well.
module simplemem_ctrl #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          mem_csN,
  output logic          mem_oeN,
  output logic          mem_wrN,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  // Wait-state counts must fit the 4-bit down-counter and be at least one cycle.
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : gBadRdWait
    $error("simplemem_ctrl: RD_WAIT must be in 1..15");
  end
  if (WR_SETUP < 1 || WR_SETUP > 15) begin : gBadWrSetup
    $error("simplemem_ctrl: WR_SETUP must be in 1..15");
  end
  if (WR_PULSE < 1 || WR_PULSE > 15) begin : gBadWrPulse
    $error("simplemem_ctrl: WR_PULSE must be in 1..15");
  end
  if (WR_HOLD < 1 || WR_HOLD > 15) begin : gBadWrHold
    $error("simplemem_ctrl: WR_HOLD must be in 1..15");
  end

  // Counter preload for a phase lasting 'cycles' clocks: the phase ends on
  // the edge where the counter has reached zero.
  function automatic logic [3:0] loadOf(input int cycles);
    return 4'(cycles - 1);
  endfunction

  localparam logic [3:0] RD_LOAD  = loadOf(RD_WAIT);
  localparam logic [3:0] WSU_LOAD = loadOf(WR_SETUP);
  localparam logic [3:0] WPL_LOAD = loadOf(WR_PULSE);
  localparam logic [3:0] WHD_LOAD = loadOf(WR_HOLD);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WSU  = 3'd2,
    WPL  = 3'd3,
    WHD  = 3'd4,
    TURN = 3'd5
  } state_t;

  state_t        stateR;
  logic [3:0]    cntR;
  logic [DW-1:0] wdataR;
  logic          driveR;

  // Bus is driven only while a write sequence owns it; otherwise released.
  assign mem_data = driveR ? wdataR : {DW{1'bz}};

  // Sequencer: state, phase counter, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateR   <= IDLE;
      cntR     <= 4'd0;
      wdataR   <= {DW{1'b0}};
      driveR   <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rdata    <= {DW{1'b0}};
      mem_csN  <= 1'b1;
      mem_oeN  <= 1'b1;
      mem_wrN  <= 1'b1;
      mem_addr <= {AW{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          done <= 1'b0;
          if (req) begin
            // Accept: address and data stay frozen until the next accept.
            mem_addr <= addr;
            wdataR   <= wdata;
            ready    <= 1'b0;
            mem_csN  <= 1'b0;
            if (we) begin
              stateR <= WSU;
              cntR   <= WSU_LOAD;
              driveR <= 1'b1;
            end else begin
              stateR  <= RD;
              cntR    <= RD_LOAD;
              mem_oeN <= 1'b0;
            end
          end else begin
            ready <= 1'b1;
          end
        end

        RD: begin
          if (cntR == 4'd0) begin
            // Memory has been enabled for the full wait time; capture now.
            rdata   <= mem_data;
            stateR  <= TURN;
            mem_csN <= 1'b1;
            mem_oeN <= 1'b1;
            done    <= 1'b1;
          end else begin
            cntR <= cntR - 4'd1;
          end
        end

        WSU: begin
          if (cntR == 4'd0) begin
            stateR  <= WPL;
            cntR    <= WPL_LOAD;
            mem_wrN <= 1'b0;
          end else begin
            cntR <= cntR - 4'd1;
          end
        end

        WPL: begin
          if (cntR == 4'd0) begin
            stateR  <= WHD;
            cntR    <= WHD_LOAD;
            mem_wrN <= 1'b1;
          end else begin
            cntR <= cntR - 4'd1;
          end
        end

        WHD: begin
          if (cntR == 4'd0) begin
            stateR  <= TURN;
            mem_csN <= 1'b1;
            driveR  <= 1'b0;
            done    <= 1'b1;
          end else begin
            cntR <= cntR - 4'd1;
          end
        end

        TURN: begin
          // Bus-turnaround cycle; requests are ignored until IDLE.
          stateR <= IDLE;
          cntR   <= 4'd0;
          done   <= 1'b0;
          ready  <= 1'b1;
        end

        default: begin
          stateR  <= IDLE;
          cntR    <= 4'd0;
          driveR  <= 1'b0;
          done    <= 1'b0;
          ready   <= 1'b1;
          mem_csN <= 1'b1;
          mem_oeN <= 1'b1;
          mem_wrN <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplemem_ctrl.sv
// tb_simplemem_ctrl: randomized self-checking bench for simplemem_ctrl.
// Two controllers: default timing and the all-ones timing build, each with
// its own behavioural simplemem device. Expected per-cycle waveforms are
// derived from phase lengths with plain arithmetic; memory contents come
// from a reference array.
module tb_simplemem_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic modelOn = 1'b0;

  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ready0, done0, csN0, oeN0, wrN0;
  logic          ready1, done1, csN1, oeN1, wrN1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] memAddr0, memAddr1;
  wire  [DW-1:0] bus0, bus1;

  logic          probeEn0 = 1'b0, probeEn1 = 1'b0;
  logic [DW-1:0] probeVal0 = '0, probeVal1 = '0;
  logic [DW-1:0] devMem0 [1024];
  logic [DW-1:0] devMem1 [1024];

  // Reference model state
  logic [DW-1:0] refMem [2][1024];
  logic [AW-1:0] lastAddr [2];
  logic [DW-1:0] lastRdata [2];
  logic [DW-1:0] latchedW [2];
  logic          holding [2];

  // Observed values for the selected controller
  logic          oReady, oDone, oCs, oOe, oWr;
  logic [DW-1:0] oRdata, oBus, oProbe;
  logic [AW-1:0] oAddr;

  int checks = 0;
  int errors = 0;

  simplemem_ctrl dut0 (
    .clk(clk), .rstN(rstN), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .done(done0), .rdata(rdata0),
    .mem_csN(csN0), .mem_oeN(oeN0), .mem_wrN(wrN0), .mem_addr(memAddr0), .mem_data(bus0)
  );

  simplemem_ctrl #(.RD_WAIT(1), .WR_SETUP(1), .WR_PULSE(1), .WR_HOLD(1)) dut1 (
    .clk(clk), .rstN(rstN), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .done(done1), .rdata(rdata1),
    .mem_csN(csN1), .mem_oeN(oeN1), .mem_wrN(wrN1), .mem_addr(memAddr1), .mem_data(bus1)
  );

  always #5 clk = ~clk;

  // simplemem devices: drive on csN&oeN low, otherwise the bench may probe the bus.
  assign bus0 = (!csN0 && !oeN0) ? devMem0[memAddr0] : (probeEn0 ? probeVal0 : {DW{1'bz}});
  assign bus1 = (!csN1 && !oeN1) ? devMem1[memAddr1] : (probeEn1 ? probeVal1 : {DW{1'bz}});

  always @(posedge wrN0) if (modelOn && !csN0) devMem0[memAddr0] <= bus0;
  always @(posedge wrN1) if (modelOn && !csN1) devMem1[memAddr1] <= bus1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic driveIn(input int sel, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 1) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // The probe pattern is the complement of the controller's latched write
  // data, so any unwanted drive corrupts what the bench reads back.
  task automatic setProbe(input int sel, input logic en);
    if (sel == 1) begin
      probeEn1 = en; probeVal1 = ~latchedW[1];
    end else begin
      probeEn0 = en; probeVal0 = ~latchedW[0];
    end
  endtask

  task automatic observe(input int sel);
    if (sel == 1) begin
      oReady = ready1; oDone = done1; oCs = csN1; oOe = oeN1; oWr = wrN1;
      oRdata = rdata1; oAddr = memAddr1; oBus = bus1; oProbe = probeVal1;
    end else begin
      oReady = ready0; oDone = done0; oCs = csN0; oOe = oeN0; oWr = wrN0;
      oRdata = rdata0; oAddr = memAddr0; oBus = bus0; oProbe = probeVal0;
    end
  endtask

  task automatic checkIdle(input int sel);
    checkEq("idle_ready", 32'(oReady), 32'(1'b1));
    checkEq("idle_done", 32'(oDone), 32'(1'b0));
    checkEq("idle_csN", 32'(oCs), 32'(1'b1));
    checkEq("idle_oeN", 32'(oOe), 32'(1'b1));
    checkEq("idle_wrN", 32'(oWr), 32'(1'b1));
    checkEq("idle_addr", 32'(oAddr), 32'(lastAddr[sel]));
    checkEq("idle_rdata", 32'(oRdata), 32'(lastRdata[sel]));
    checkEq("idle_busZ", 32'(oBus), 32'(oProbe));
  endtask

  task automatic idleCycle(input int sel);
    @(posedge clk);
    #1 setProbe(sel, 1'b1);
    @(negedge clk);
    observe(sel);
    checkIdle(sel);
  endtask

  // Reset mid-transaction: everything must release before the next clock.
  task automatic abortNow(input int sel);
    rstN = 1'b0;
    #1 setProbe(sel, 1'b1);
    #1 observe(sel);
    checkEq("abort_csN", 32'(oCs), 32'(1'b1));
    checkEq("abort_oeN", 32'(oOe), 32'(1'b1));
    checkEq("abort_wrN", 32'(oWr), 32'(1'b1));
    checkEq("abort_done", 32'(oDone), 32'(1'b0));
    checkEq("abort_busZ", 32'(oBus), 32'(oProbe));
    for (int s = 0; s < 2; s++) begin
      lastAddr[s] = '0; lastRdata[s] = '0; latchedW[s] = '0; holding[s] = 1'b0;
      driveIn(s, 1'b0, 1'b0, '0, '0);
    end
    @(posedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic runTxn(input int sel, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap, input logic holdOut,
                        input int abortAt);
    int rw, s, p, h, lat;
    logic expCs, expOe, expWr, drv;
    logic [DW-1:0] expRd;
    if (sel == 1) begin
      rw = 1; s = 1; p = 1; h = 1;
    end else begin
      rw = 2; s = 1; p = 2; h = 1;
    end
    lat = w ? (s + p + h + 1) : (rw + 1);
    driveIn(sel, holding[sel], w, a, d);
    idleCycle(sel);
    if (!holding[sel]) begin
      for (int g = 0; g < gap; g++) idleCycle(sel);
      driveIn(sel, 1'b1, w, a, d);
    end
    @(posedge clk);
    latchedW[sel] = d;
    for (int k = 1; k <= lat; k++) begin
      if (!w) begin
        expCs = (k <= rw) ? 1'b0 : 1'b1;
        expOe = expCs;
        expWr = 1'b1;
        drv   = 1'b0;
      end else begin
        expCs = (k < lat) ? 1'b0 : 1'b1;
        expOe = 1'b1;
        expWr = (k > s && k <= s + p) ? 1'b0 : 1'b1;
        drv   = (k < lat);
      end
      expRd = (k == lat && !w) ? refMem[sel][a] : lastRdata[sel];
      #1 setProbe(sel, !drv);
      @(negedge clk);
      observe(sel);
      checkEq("csN", 32'(oCs), 32'(expCs));
      checkEq("oeN", 32'(oOe), 32'(expOe));
      checkEq("wrN", 32'(oWr), 32'(expWr));
      checkEq("done", 32'(oDone), 32'(k == lat));
      checkEq("ready", 32'(oReady), 32'(1'b0));
      checkEq("memAddr", 32'(oAddr), 32'(a));
      checkEq("rdata", 32'(oRdata), 32'(expRd));
      if (drv) checkEq("bus_wdata", 32'(oBus), 32'(d));
      else if (!w && k <= rw) checkEq("bus_read", 32'(oBus), 32'(refMem[sel][a]));
      else checkEq("bus_z", 32'(oBus), 32'(oProbe));
      if (k == abortAt) begin
        abortNow(sel);
        return;
      end
      if (k < lat) begin
        driveIn(sel, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        @(posedge clk);
      end else begin
        driveIn(sel, holdOut, 1'($urandom), AW'($urandom), DW'($urandom));
      end
    end
    holding[sel] = holdOut;
    lastAddr[sel] = a;
    if (w) refMem[sel][a] = d;
    else lastRdata[sel] = refMem[sel][a];
  endtask

  initial begin
    int sel, nsel, gap;
    logic w, hold;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    for (int s = 0; s < 2; s++) begin
      lastAddr[s] = '0; lastRdata[s] = '0; latchedW[s] = '0; holding[s] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) begin
      refMem[0][i] = DW'($urandom);
      refMem[1][i] = DW'($urandom);
      devMem0[i] <= refMem[0][i];
      devMem1[i] <= refMem[1][i];
    end

    // T1: reset values while held, then idle after release
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      setProbe(s, 1'b1);
      #1 observe(s);
      checkIdle(s);
    end
    rstN = 1'b1;
    modelOn = 1'b1;
    idleCycle(0);
    idleCycle(1);

    // T2..T4: default-timing directed transactions
    runTxn(0, 1'b1, 10'h3A5, 8'hC3, 1, 1'b0, 0);
    runTxn(0, 1'b0, 10'h3A5, 8'h17, 0, 1'b0, 0);
    runTxn(0, 1'b1, 10'h000, 8'h5A, 0, 1'b1, 0);
    runTxn(0, 1'b0, 10'h3FF, 8'h00, 0, 1'b0, 0);
    runTxn(0, 1'b0, 10'h000, 8'h81, 0, 1'b0, 0);

    // T5: reset during the second write-pulse cycle, then a clean retry
    runTxn(0, 1'b1, 10'h2AA, 8'h66, 1, 1'b0, 3);
    idleCycle(0);
    runTxn(0, 1'b1, 10'h2AA, 8'h99, 0, 1'b0, 0);
    runTxn(0, 1'b0, 10'h2AA, 8'h42, 1, 1'b0, 0);

    // T6: minimum-timing build
    runTxn(1, 1'b1, 10'h155, 8'hFF, 0, 1'b1, 0);
    runTxn(1, 1'b0, 10'h155, 8'h3C, 0, 1'b0, 0);

    // Randomized traffic across both builds
    sel = int'($urandom_range(0, 1));
    for (int i = 0; i < 60; i++) begin
      nsel = int'($urandom_range(0, 1));
      w = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 10'h000;
        1:       a = 10'h3FF;
        default: a = AW'($urandom);
      endcase
      d = DW'($urandom);
      gap = int'($urandom_range(0, 2));
      hold = (nsel == sel) && ($urandom_range(0, 1) == 1);
      if (i == 59) hold = 1'b0;
      runTxn(sel, w, a, d, gap, hold, 0);
      sel = nsel;
    end
    idleCycle(0);
    idleCycle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
